shr33_seq: RTL and testbench

SHR33_SEQ -- requirements
Module: shr33_seq

---
 rtl/shr33_pkg.sv | 10 +
 rtl/shr33_step.sv | 19 +
 rtl/shr33_seq.sv | 68 ++++++
 tb/tb_shr33_seq.sv | 139 +++++++++++++
 4 files changed

// File: rtl/shr33_pkg.sv
// Shared constants and state encoding for the sequential 33-bit right shifter.
package shr33_pkg;
    localparam int WIDTH     = 33;
    localparam int MAX_SHIFT = 33;
    localparam int STEP_MAX  = 3;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_SHIFT = 2'b01;
    localparam logic [1:0] S_DONE  = 2'b10;
endpackage

// File: rtl/shr33_step.sv
// Combinational 0..3-bit right shift with a fill bit, one 4:1 mux per output bit.
import shr33_pkg::*;

module shr33_step (
    input  logic [WIDTH-1:0] d_in,
    input  logic             fill,
    input  logic [1:0]       step,
    output logic [WIDTH-1:0] d_out
);
    logic [WIDTH+2:0] ext;

    // Fill bits sit above the MSB so every bit indexes the same way.
    assign ext = {{3{fill}}, d_in};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign d_out[i] = step[1] ? (step[0] ? ext[i+3] : ext[i+2])
                                  : (step[0] ? ext[i+1] : ext[i]);
    end
endmodule

// File: rtl/shr33_seq.sv
// Multi-cycle logical/arithmetic right shifter: up to STEP_MAX bits per SHIFT cycle.
import shr33_pkg::*;

module shr33_seq #(
    parameter int WIDTH    = 33,
    parameter int STEP_MAX = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] d_in,
    input  logic [5:0]       shamt,
    input  logic             arith,
    output logic [WIDTH-1:0] d_out,
    output logic             busy,
    output logic             done
);
    logic [1:0]       state;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] shifted;
    logic             fill;
    logic [5:0]       rem;
    logic [5:0]       shamt_clip;
    logic [1:0]       step;

    assign shamt_clip = (shamt > 6'(MAX_SHIFT)) ? 6'(MAX_SHIFT) : shamt;
    assign step       = (rem > 6'(STEP_MAX)) ? 2'(STEP_MAX) : rem[1:0];

    shr33_step u_step (
        .d_in  (data),
        .fill  (fill),
        .step  (step),
        .d_out (shifted)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            data  <= '0;
            fill  <= 1'b0;
            rem   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        data  <= d_in;
                        fill  <= arith & d_in[WIDTH-1];
                        rem   <= shamt_clip;
                        state <= (shamt_clip == 6'd0) ? S_DONE : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    data <= shifted;
                    rem  <= rem - {4'b0, step};
                    // Leave on the edge that applies the last partial/full step.
                    if (rem <= 6'(STEP_MAX))
                        state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign d_out = data;
    assign busy  = (state == S_SHIFT) || (state == S_DONE);
    assign done  = (state == S_DONE);
endmodule

// File: tb/tb_shr33_seq.sv
// Directed bench for shr33_seq: vector table plus busy, back-to-back and reset-abort sequences.
module tb_shr33_seq;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [32:0] d_in = '0;
    logic [5:0]  shamt = '0;
    logic        arith = 1'b0;
    logic [32:0] d_out;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    shr33_seq dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .d_in    (d_in),
        .shamt   (shamt),
        .arith   (arith),
        .d_out   (d_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [32:0] d;
        logic [5:0]  sh;
        logic        a;
        logic [32:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one operation from IDLE, scramble inputs after acceptance, check latency and result.
    task automatic run_op(input string name, input logic [32:0] d, input logic [5:0] sh,
                          input logic a, input logic [32:0] exp, input int lat);
        int cyc;
        @(negedge clk);
        d_in = d; shamt = sh; arith = a; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        d_in = ~d; shamt = 6'd2; arith = ~a;
        cyc = 1;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " latency"}, 64'(cyc), 64'(lat));
        check({name, " d_out"}, 64'(d_out), 64'(exp));
        @(negedge clk);
        check({name, " done one cycle"}, 64'({busy, done}), 64'b0);
        check({name, " d_out hold"}, 64'(d_out), 64'(exp));
    endtask

    initial begin
        int cyc;
        bit seen;

        vecs[0]  = '{33'h1_0000_0000, 6'd4,  1'b0, 33'h0_1000_0000, 3};
        vecs[1]  = '{33'h1_0000_0000, 6'd4,  1'b1, 33'h1_F000_0000, 3};
        vecs[2]  = '{33'h0_1234_5678, 6'd0,  1'b0, 33'h0_1234_5678, 1};
        vecs[3]  = '{33'h1_0000_0000, 6'd40, 1'b1, 33'h1_FFFF_FFFF, 12};
        vecs[4]  = '{33'h1_0000_0000, 6'd40, 1'b0, 33'h0_0000_0000, 12};
        vecs[5]  = '{33'h1_FFFF_FFFF, 6'd33, 1'b0, 33'h0_0000_0000, 12};
        vecs[6]  = '{33'h0_8765_4321, 6'd1,  1'b1, 33'h0_43B2_A190, 2};
        vecs[7]  = '{33'h1_2345_6789, 6'd32, 1'b0, 33'h0_0000_0001, 12};
        vecs[8]  = '{33'h1_0000_0001, 6'd6,  1'b0, 33'h0_0400_0000, 3};
        vecs[9]  = '{33'h0_0000_00F0, 6'd3,  1'b0, 33'h0_0000_001E, 2};
        vecs[10] = '{33'h0_FFFF_FFFF, 6'd63, 1'b1, 33'h0_0000_0000, 12};

        #12;
        check("reset outputs", 64'({d_out, busy, done}), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 11; i++)
            run_op($sformatf("vec%0d", i), vecs[i].d, vecs[i].sh, vecs[i].a, vecs[i].exp, vecs[i].lat);

        // Start pulsed mid-SHIFT must be ignored; start held through DONE is accepted only in IDLE.
        @(negedge clk);
        d_in = 33'h1_0000_0000; shamt = 6'd4; arith = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy after accept", 64'(busy), 64'd1);
        d_in = 33'h0_1234_5678; shamt = 6'd0; arith = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("ignored start done", 64'(done), 64'd1);
        check("ignored start d_out", 64'(d_out), 64'(33'h0_1000_0000));
        d_in = 33'h0_0ABC_DEF0; shamt = 6'd0; arith = 1'b0; start = 1'b1;
        @(negedge clk);
        check("start in DONE ignored", 64'({busy, done}), 64'b0);
        check("d_out after DONE", 64'(d_out), 64'(33'h0_1000_0000));
        @(negedge clk);
        start = 1'b0;
        check("back-to-back done", 64'(done), 64'd1);
        check("back-to-back d_out", 64'(d_out), 64'(33'h0_0ABC_DEF0));

        // Reset dropped in the second SHIFT cycle of a shamt=9 operation.
        @(negedge clk);
        d_in = 33'h1_8000_0000; shamt = 6'd9; arith = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort pre busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("abort outputs", 64'({d_out, busy, done}), 64'(0));
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        for (cyc = 0; cyc < 15; cyc++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("no done after abort", 64'(seen), 64'd0);

        run_op("restart", 33'h1_0000_0000, 6'd9, 1'b1, 33'h1_FF80_0000, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
